// File: rtl/mips_pkg.sv
// Shared MIPS encodings: controller states, opcodes, mux selects, ALU ops,
// and the control word passed from the decoder to the controller.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ORIEX   = 4'd10,
    IMMWB   = 4'd11,
    JUMP    = 4'd12
  } statetype;

  // Opcodes shared with the single-cycle decoder.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU B operand select.
  localparam logic [2:0] SRCB_REG    = 3'b000;
  localparam logic [2:0] SRCB_FOUR   = 3'b001;
  localparam logic [2:0] SRCB_SIGN   = 3'b010;
  localparam logic [2:0] SRCB_ZERO   = 3'b011;
  localparam logic [2:0] SRCB_BRANCH = 3'b100;

  // PC source select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU operation.
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       ne;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [2:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       half;
    logic       b;
    logic       lbu;
    logic       illegal;
  } ctrl_t;

  // True for every opcode this controller knows how to sequence.
  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_LH, OP_LB, OP_LBU, OP_SW,
      OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J: op_supported = 1'b1;
      default:                               op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode for the multicycle controller.
// Moore outputs come from the state and the opcode latched in DECODE;
// only the illegal flag looks at the live opcode.
module mc_ctrl_decode
  import mips_pkg::*;
(
  input  statetype    state_i,
  input  logic [5:0]  op_i,
  input  logic [5:0]  op_q_i,
  output ctrl_t       ctrl_o
);

  // Per-state control word; every field not driven by a state stays 0.
  always_comb begin
    // NOTE: assigning the whole word first means every path drives every
    // field, so no latch can be inferred for the unlisted outputs.
    ctrl_o = '0;
    unique case (state_i)
      FETCH: begin
        ctrl_o.irwrite = 1'b1;
        ctrl_o.pcwrite = 1'b1;
        ctrl_o.alusrcb = SRCB_FOUR;
      end
      DECODE: begin
        ctrl_o.alusrcb = SRCB_BRANCH;
        ctrl_o.illegal = !op_supported(op_i);
      end
      MEMADR: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_SIGN;
      end
      MEMRD: ctrl_o.iord = 1'b1;
      MEMWB: begin
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.half     = (op_q_i == OP_LH) || (op_q_i == OP_LB);
        ctrl_o.b        = (op_q_i == OP_LB);
        ctrl_o.lbu      = (op_q_i == OP_LBU);
      end
      MEMWR: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      EXECUTE: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALU_FUNCT;
      end
      ALUWB: begin
        ctrl_o.regdst   = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      BRANCH: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALU_SUB;
        ctrl_o.branch  = 1'b1;
        ctrl_o.pcsrc   = PCSRC_ALUOUT;
        ctrl_o.ne      = (op_q_i == OP_BNE);
      end
      ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_SIGN;
      end
      ORIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_ZERO;
        ctrl_o.aluop   = ALU_OR;
      end
      IMMWB: ctrl_o.regwrite = 1'b1;
      JUMP: begin
        ctrl_o.pcwrite = 1'b1;
        ctrl_o.pcsrc   = PCSRC_JUMP;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: state register, next-state logic,
// mem_ready gating of the fetch strobes and reset masking of all strobes.
module mc_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       branch,
  output logic       ne,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [2:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] aluop,
  output logic       half,
  output logic       b,
  output logic       lbu,
  output logic       illegal,
  output logic [3:0] state
);

  statetype   state_q, state_d;
  logic [5:0] op_q, op_d;
  ctrl_t      ctrl_raw, ctrl;

  // State and latched opcode registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= FETCH;
      op_q    <= OP_RTYPE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic; the opcode is captured in DECODE so later states
  // (MEMWB width, BRANCH polarity) ignore IR changes.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      FETCH: if (mem_ready) state_d = DECODE;
      DECODE: begin
        op_d = op;
        case (op)
          OP_LW, OP_LH, OP_LB, OP_LBU, OP_SW: state_d = MEMADR;
          OP_RTYPE:                          state_d = EXECUTE;
          OP_BEQ, OP_BNE:                    state_d = BRANCH;
          OP_ADDI:                           state_d = ADDIEX;
          OP_ORI:                            state_d = ORIEX;
          OP_J:                              state_d = JUMP;
          default:                           state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (mem_ready) state_d = MEMWB;
      MEMWB:   state_d = FETCH;
      MEMWR:   if (mem_ready) state_d = FETCH;
      EXECUTE: state_d = ALUWB;
      ALUWB:   state_d = FETCH;
      BRANCH:  state_d = FETCH;
      ADDIEX:  state_d = IMMWB;
      ORIEX:   state_d = IMMWB;
      IMMWB:   state_d = FETCH;
      JUMP:    state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state_i (state_q),
    .op_i    (op),
    .op_q_i  (op_q),
    .ctrl_o  (ctrl_raw)
  );

  // Fetch strobes wait for memory; reset forces every strobe low while the
  // selects already show FETCH values because the state is held there.
  always_comb begin
    ctrl = ctrl_raw;
    if (state_q == FETCH && !mem_ready) begin
      ctrl.irwrite = 1'b0;
      ctrl.pcwrite = 1'b0;
    end
    if (reset) begin
      ctrl.pcwrite  = 1'b0;
      ctrl.irwrite  = 1'b0;
      ctrl.memwrite = 1'b0;
      ctrl.regwrite = 1'b0;
      ctrl.branch   = 1'b0;
      ctrl.illegal  = 1'b0;
    end
  end

  assign pcwrite  = ctrl.pcwrite;
  assign branch   = ctrl.branch;
  assign ne       = ctrl.ne;
  assign iord     = ctrl.iord;
  assign memwrite = ctrl.memwrite;
  assign irwrite  = ctrl.irwrite;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign regwrite = ctrl.regwrite;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign aluop    = ctrl.aluop;
  assign half     = ctrl.half;
  assign b        = ctrl.b;
  assign lbu      = ctrl.lbu;
  assign illegal  = ctrl.illegal;
  assign state    = state_q;

endmodule
